tff_count_ctrl: RTL and testbench

Sequencing controller for a bank of toggle flip-flops. On a start request it latches a terminal value, drives the bank's per-bit toggle enables so the bank counts up from 0 to that value, and reports completion with a one-cycle done pulse. It clears the bank back to zero using toggles only. It sits between the team's control logic and the flip-flop datapath, as the standard way to run a TFF bank as a bounded counter.

---
 rtl/tff_ctrl_pkg.sv | 12 +
 rtl/toggle_cell.sv | 20 ++
 rtl/tff_count_ctrl.sv | 100 ++++++++++
 tb/tb_tff_count_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tff_ctrl_pkg.sv
// Shared types and defaults for the TFF bank sequencing controller.
package tff_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/toggle_cell.sv
// Single toggle flip-flop: q inverts on every rising edge where t is high.
module toggle_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Runs a bank of toggle flip-flops as a bounded up-counter 0..period, then clears it.
// Optional freeze input enabled by defining TFF_CTRL_HOLD_EN.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] period,
`ifdef TFF_CTRL_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    state_t           state_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] t_vec_c;
    logic [WIDTH-1:0] qbar_c;
    logic             hold_c;
    logic             hit_c;

`ifdef TFF_CTRL_HOLD_EN
    assign hold_c = hold;
`else
    assign hold_c = 1'b0;
`endif

    assign hit_c = (count == period_q);

    // Count storage lives entirely in the toggle cells.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        toggle_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .t    (t_vec_c[i]),
            .q    (count[i]),
            .qbar (qbar_c[i])
        );
    end

    // Toggle vector: ripple-carry increment in RUN, self-clear in DONE.
    always_comb begin : p_toggle
        logic carry;
        t_vec_c = '0;
        carry   = 1'b1;
        case (state_q)
            RUN: begin
                if (!hold_c && !hit_c) begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        t_vec_c[i] = carry;
                        carry      = carry & ~qbar_c[i];
                    end
                end
            end
            DONE:    t_vec_c = count;
            default: t_vec_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        period_q <= period;
                        state_q  <= RUN;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (!hold_c && hit_c) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Randomized self-checking bench for tff_count_ctrl against a cycle-sequence model.
module tb_tff_count_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int MAXV = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] period;
    logic             hold;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;

    int checks;
    int errors;

    tff_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .period (period),
`ifdef TFF_CTRL_HOLD_EN
        .hold   (hold),
`endif
        .busy   (busy),
        .done   (done),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 40) begin
            tick();
            n++;
        end
        if (busy || done) check("idle_timeout", 1, 0);
        tick();
    endtask

    // Expected count during RUN cycle idx: linear ramp, flattened while held.
    function automatic int model_count(input int idx, input int hold_at, input int hold_len);
        if (hold_len == 0 || idx <= hold_at) return idx;
        if (idx <= hold_at + hold_len) return hold_at;
        return idx - hold_len;
    endfunction

    task automatic run_one(input int p, input int hold_at, input int hold_len, input bit keep_start);
        int n_run;
        start  = 1'b1;
        period = WIDTH'(p);
        tick();
        if (!keep_start) start = 1'b0;
        period = WIDTH'($urandom);
        n_run  = p + 1 + hold_len;
        for (int idx = 0; idx < n_run; idx++) begin
            check("run_busy", int'(busy), 1);
            check("run_done", int'(done), 0);
            check("run_count", int'(count), model_count(idx, hold_at, hold_len));
            hold = (hold_len > 0) && (idx >= hold_at) && (idx < hold_at + hold_len);
            tick();
        end
        hold = 1'b0;
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("done_count", int'(count), p);
        tick();
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_count", int'(count), 0);
        if (keep_start) begin
            tick();
            check("restart_busy", int'(busy), 1);
            check("restart_count", int'(count), 0);
            start = 1'b0;
            wait_idle();
        end
    endtask

    initial begin
        int p;
        int h_at;
        int h_len;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        period = '0;
        hold   = 1'b0;

        // Asynchronous reset, observed before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Idle with no start: nothing moves, hold is ignored.
        for (int i = 0; i < 4; i++) begin
            period = WIDTH'($urandom);
            hold   = 1'($urandom);
            tick();
            check("idle_still_count", int'(count), 0);
            check("idle_still_busy", int'(busy), 0);
        end
        hold = 1'b0;

        run_one(5, 0, 0, 1'b0);
        run_one(0, 0, 0, 1'b0);
        run_one(MAXV, 0, 0, 1'b1);

        // Mid-run reset at count 4 aborts with no done pulse.
        start  = 1'b1;
        period = WIDTH'(9);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_abort_count", int'(count), 4);
        #2 rst = 1'b1;
        #1;
        check("abort_count", int'(count), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_abort_done", int'(done), 0);
            check("post_abort_busy", int'(busy), 0);
        end
        run_one(9, 0, 0, 1'b0);

`ifdef TFF_CTRL_HOLD_EN
        run_one(6, 2, 3, 1'b0);
`endif

        for (int r = 0; r < 24; r++) begin
            p     = int'($urandom_range(0, MAXV));
            h_at  = 0;
            h_len = 0;
`ifdef TFF_CTRL_HOLD_EN
            if ($urandom_range(0, 1) == 1) begin
                h_at  = int'($urandom_range(0, p));
                h_len = int'($urandom_range(1, 4));
            end
`endif
            run_one(p, h_at, h_len, 1'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
